slm_spi_sequencer: RTL
======================

// Module: slm_spi_sequencer
// PURPOSE
//  Sequences all SPI register traffic to the Bluejay SLM through the spi engine. Two requesters share it.
//  Requester 1 is a power-on init table of register writes; requester 2 is 2-byte host frames ([addr][data])
//  arriving from uart_rx. Each host transaction's returned SPI byte is echoed back to the PC through uart_tx.
//  Sits between uart_rx/uart_tx and spi in top, replacing the free-running led_counter trigger.
// PARAMETERS
//  INIT_LEN      4        number of init writes (1..16)
//  INIT_TABLE    64'h0    INIT_LEN x 16-bit {addr,data}; entry 0 in bits [15:0], issued first
//  SPI_TIMEOUT   4096     clocks allowed from start pulse to transaction_complete
//  BYTE_TIMEOUT  500000   idle clocks between host bytes before a partial frame is discarded (~10 ms @50 MHz)
// PORTS
//  i_clock                 in   1   system clock (sys_clk)
//  i_reset_n               in   1   asynchronous, active-low reset
//  i_rx_dv                 in   1   uart_rx byte valid, 1-cycle pulse
//  i_rx_byte               in   8   uart_rx byte
//  i_tx_active             in   1   uart_tx busy
//  o_tx_dv                 out  1   uart_tx start, 1-cycle pulse
//  o_tx_byte               out  8   byte to send
//  o_start_transfer        out  1   spi start, 1-cycle pulse
//  o_tx_upper_byte         out  8   SPI address byte, held stable from start pulse until complete
//  o_tx_lower_byte         out  8   SPI data byte, held the same way
//  i_spi_busy              in   1   spi engine busy
//  i_transaction_complete  in   1   spi done, 1-cycle pulse
//  i_rx_lower_byte         in   8   byte read back by spi, valid with complete
//  o_init_done             out  1   init table finished (sticky)
//  o_error                 out  1   sticky: SPI timeout or host frame overrun
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; init index 0; frame assembler empty; pending flag clear.
//  Frame assembler: always runs, even during init.
//   - Byte 1 latches the address; byte 2 latches the data and sets pending.
//   - Timer restarts on every byte. If it reaches BYTE_TIMEOUT with 1 byte held, that byte is dropped.
//   - If byte 2 completes a frame while pending is already set, the new frame is dropped and o_error is set.
//  FSM states: IDLE, ISSUE, WAIT, RESP, GUARD.
//   - IDLE: if !o_init_done, load INIT_TABLE[idx] -> ISSUE.
//     Else if pending, load the host frame, clear pending, mark host -> ISSUE.
//     Init always wins; host frames wait until o_init_done.
//   - ISSUE: wait for i_spi_busy==0, then assert o_start_transfer for exactly 1 cycle -> WAIT.
//   - WAIT: on i_transaction_complete:
//     - init transaction: idx++; if idx==INIT_LEN-1, set o_init_done. -> IDLE.
//     - host transaction: capture i_rx_lower_byte -> RESP.
//     Timeout: a counter clears on the start pulse. At SPI_TIMEOUT, set o_error.
//     - init transaction: skip the entry (idx advances as on completion).
//     - host transaction: response byte 8'hEE -> RESP.
//   - RESP: wait for i_tx_active==0, then o_tx_dv=1 for 1 cycle with o_tx_byte -> GUARD.
//   - GUARD: 1 cycle, so uart_tx can raise i_tx_active -> IDLE.
//  Latency: host byte 2 dv -> o_start_transfer is 3 cycles when idle and spi not busy.
//  Simultaneous events: complete and timeout in the same cycle count as complete.
//   A host byte arriving in the cycle IDLE takes the pending frame is accepted as a new byte 1.
//  Reset mid-transfer: all state clears immediately and init restarts from entry 0.
//   The spi engine is reset by the same system reset.
//  Counters: timeout counters saturate and never wrap; idx is 4 bits wide.
// TESTING
//  1. INIT_LEN=2, table {16'h0301,16'hF800}, spi model completes in 40 clk:
//     -> starts carry upper/lower F8/00, then 03/01; o_init_done rises; no o_tx_dv.
//  2. After init, host bytes 8'hF8,8'h00; model returns 8'h5A:
//     -> one start with F8/00; exactly one o_tx_dv with byte 8'h5A.
//  3. Host frame sent during init:
//     -> issued only after o_init_done; response correct; o_error stays 0.
//  4. Model never completes:
//     -> o_error at SPI_TIMEOUT cycles after start; host case sends 8'hEE; FSM returns to IDLE.
//  5. Single host byte, then BYTE_TIMEOUT+1 idle, then 8'h10,8'h22:
//     -> exactly one transaction with 10/22.
//  6. i_reset_n low while in WAIT:
//     -> outputs 0 asynchronously; after release, init replays from entry 0.

Source files
------------

// File: rtl/slm_spi_sequencer.sv
// slm_spi_sequencer: arbitrates the power-on init table and 2-byte host frames onto the SPI engine,
// echoing each host transaction's read-back byte to the UART transmitter.
module slm_spi_sequencer #(
    parameter int                     INIT_LEN     = 4,
    parameter logic [INIT_LEN*16-1:0] INIT_TABLE   = '0,
    parameter int                     SPI_TIMEOUT  = 4096,
    parameter int                     BYTE_TIMEOUT = 500000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    input  logic       i_tx_active,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    output logic       o_start_transfer,
    output logic [7:0] o_tx_upper_byte,
    output logic [7:0] o_tx_lower_byte,
    input  logic       i_spi_busy,
    input  logic       i_transaction_complete,
    input  logic [7:0] i_rx_lower_byte,
    output logic       o_init_done,
    output logic       o_error
);
    localparam int SW = $clog2(SPI_TIMEOUT + 1);
    localparam int BW = $clog2(BYTE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GUARD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          host_q, host_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic [7:0]    up_q, up_d;
    logic [7:0]    lo_q, lo_d;
    logic          txdv_q, txdv_d;
    logic [7:0]    txb_q, txb_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          b1v_q, b1v_d;
    logic [7:0]    b1_q, b1_d;
    logic          pend_q, pend_d;
    logic [7:0]    faddr_q, faddr_d;
    logic [7:0]    fdata_q, fdata_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          take;
    logic          spi_to;
    logic [15:0]   init_tbl [16];

    for (genvar g = 0; g < 16; g++) begin : g_tbl
        if (g < INIT_LEN) begin : g_used
            assign init_tbl[g] = INIT_TABLE[g*16 +: 16];
        end else begin : g_pad
            assign init_tbl[g] = '0;
        end
    end

    assign spi_to = scnt_q >= SW'(SPI_TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        host_d  = host_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        up_d    = up_q;
        lo_d    = lo_q;
        txdv_d  = 1'b0;
        txb_d   = txb_q;
        scnt_d  = (scnt_q == SW'(SPI_TIMEOUT)) ? scnt_q : scnt_q + 1'b1;
        b1v_d   = b1v_q;
        b1_d    = b1_q;
        pend_d  = pend_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        bcnt_d  = (bcnt_q == BW'(BYTE_TIMEOUT)) ? bcnt_q : bcnt_q + 1'b1;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!done_q) begin
                    {up_d, lo_d} = init_tbl[idx_q];
                    host_d       = 1'b0;
                    state_d      = ISSUE;
                end else if (pend_q) begin
                    {up_d, lo_d} = {faddr_q, fdata_q};
                    host_d       = 1'b1;
                    take         = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_spi_busy) begin
                    start_d = 1'b1;
                    scnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // completion takes priority over a coincident timeout
                if (i_transaction_complete || spi_to) begin
                    err_d = err_q | !i_transaction_complete;
                    if (host_q) begin
                        txb_d   = i_transaction_complete ? i_rx_lower_byte : 8'hEE;
                        state_d = RESP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        done_d  = done_q | (idx_q == 4'(INIT_LEN - 1));
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (!i_tx_active) begin
                    txdv_d  = 1'b1;
                    state_d = GUARD;
                end
            end
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a frame being taken this cycle frees the pending slot for a new byte 2
        if (i_rx_dv) begin
            bcnt_d = '0;
            if (!b1v_q) begin
                b1v_d = 1'b1;
                b1_d  = i_rx_byte;
            end else begin
                b1v_d = 1'b0;
                if (pend_q && !take) begin
                    err_d = 1'b1;
                end else begin
                    faddr_d = b1_q;
                    fdata_d = i_rx_byte;
                    pend_d  = 1'b1;
                end
            end
        end else if (b1v_q && bcnt_q >= BW'(BYTE_TIMEOUT - 1)) begin
            b1v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            host_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            up_q    <= '0;
            lo_q    <= '0;
            txdv_q  <= 1'b0;
            txb_q   <= '0;
            scnt_q  <= '0;
            b1v_q   <= 1'b0;
            b1_q    <= '0;
            pend_q  <= 1'b0;
            faddr_q <= '0;
            fdata_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            host_q  <= host_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            up_q    <= up_d;
            lo_q    <= lo_d;
            txdv_q  <= txdv_d;
            txb_q   <= txb_d;
            scnt_q  <= scnt_d;
            b1v_q   <= b1v_d;
            b1_q    <= b1_d;
            pend_q  <= pend_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign o_tx_dv          = txdv_q;
    assign o_tx_byte        = txb_q;
    assign o_start_transfer = start_q;
    assign o_tx_upper_byte  = up_q;
    assign o_tx_lower_byte  = lo_q;
    assign o_init_done      = done_q;
    assign o_error          = err_q;
endmodule
